// File: rtl/key_debounce_multi.sv
// N-channel push-button conditioner: 2-flop synchroniser, counter debounce,
// and per-channel press / release / long-press / auto-repeat pulses.
module key_debounce_multi #(
    parameter int NUM_KEYS        = 4,
    parameter int ACTIVE_LOW      = 1,
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int LONG_CYCLES     = 50_000_000,
    parameter int REPEAT_CYCLES   = 10_000_000,
    parameter int REPEAT_EN       = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_KEYS-1:0] key_in,
    output logic [NUM_KEYS-1:0] key_state,
    output logic [NUM_KEYS-1:0] press_pulse,
    output logic [NUM_KEYS-1:0] release_pulse,
    output logic [NUM_KEYS-1:0] long_pulse,
    output logic [NUM_KEYS-1:0] repeat_pulse,
    output logic                any_press
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES);
    localparam int HW = $clog2(LONG_CYCLES);
    localparam int RW = $clog2(REPEAT_CYCLES);

    localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [DW-1:0] DB_ONE    = DW'(1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_PRE  = HW'(LONG_CYCLES - 2);
    localparam logic [HW-1:0] HOLD_ONE  = HW'(1);
    localparam logic [RW-1:0] REP_LAST  = RW'(REPEAT_CYCLES - 1);
    localparam logic [RW-1:0] REP_ONE   = RW'(1);
    localparam logic [NUM_KEYS-1:0] IDLE_PIN =
        (ACTIVE_LOW != 0) ? {NUM_KEYS{1'b1}} : {NUM_KEYS{1'b0}};

    typedef enum logic [1:0] {
        RELEASED     = 2'd0,
        PRESS_WAIT   = 2'd1,
        HELD         = 2'd2,
        RELEASE_WAIT = 2'd3
    } state_t;

    logic [NUM_KEYS-1:0] sync1_q, sync1_d, sync2_q, sync2_d;
    logic [NUM_KEYS-1:0] pr;
    state_t              state_q [NUM_KEYS];
    state_t              state_d [NUM_KEYS];
    logic [NUM_KEYS-1:0][DW-1:0] db_q, db_d;
    logic [NUM_KEYS-1:0][HW-1:0] hold_q, hold_d;
    logic [NUM_KEYS-1:0][RW-1:0] rep_q, rep_d;
    logic [NUM_KEYS-1:0] key_state_q, key_state_d;
    logic [NUM_KEYS-1:0] press_q, press_d, release_q, release_d;
    logic [NUM_KEYS-1:0] long_q, long_d, repeat_q, repeat_d;

    assign sync1_d = key_in;
    assign sync2_d = sync1_q;
    assign pr      = (ACTIVE_LOW != 0) ? ~sync2_q : sync2_q;

    // Per-channel debounce / hold FSM; counters only move in the states that own them.
    always_comb begin
        for (int k = 0; k < NUM_KEYS; k++) begin
            state_d[k]     = state_q[k];
            db_d[k]        = db_q[k];
            hold_d[k]      = hold_q[k];
            rep_d[k]       = rep_q[k];
            key_state_d[k] = key_state_q[k];
            press_d[k]     = 1'b0;
            release_d[k]   = 1'b0;
            long_d[k]      = 1'b0;
            repeat_d[k]    = 1'b0;
            case (state_q[k])
                RELEASED: begin
                    if (pr[k]) begin
                        state_d[k] = PRESS_WAIT;
                        db_d[k]    = '0;
                    end else begin
                        state_d[k] = RELEASED;
                    end
                end
                PRESS_WAIT: begin
                    if (!pr[k]) begin
                        state_d[k] = RELEASED;
                    end else if (db_q[k] == DB_LAST) begin
                        state_d[k]     = HELD;
                        press_d[k]     = 1'b1;
                        key_state_d[k] = 1'b1;
                        hold_d[k]      = '0;
                        rep_d[k]       = '0;
                    end else begin
                        db_d[k] = db_q[k] + DB_ONE;
                    end
                end
                HELD: begin
                    if (!pr[k]) begin
                        state_d[k] = RELEASE_WAIT;
                        db_d[k]    = '0;
                    end else if (hold_q[k] != HOLD_LAST) begin
                        hold_d[k] = hold_q[k] + HOLD_ONE;
                        // Saturation makes this transition happen once per press.
                        if (hold_q[k] == HOLD_PRE) begin
                            long_d[k] = 1'b1;
                            rep_d[k]  = '0;
                        end else begin
                            long_d[k] = 1'b0;
                        end
                    end else if (REPEAT_EN != 0) begin
                        if (rep_q[k] == REP_LAST) begin
                            repeat_d[k] = 1'b1;
                            rep_d[k]    = '0;
                        end else begin
                            rep_d[k] = rep_q[k] + REP_ONE;
                        end
                    end else begin
                        rep_d[k] = rep_q[k];
                    end
                end
                RELEASE_WAIT: begin
                    if (pr[k]) begin
                        state_d[k] = HELD;
                    end else if (db_q[k] == DB_LAST) begin
                        state_d[k]     = RELEASED;
                        release_d[k]   = 1'b1;
                        key_state_d[k] = 1'b0;
                    end else begin
                        db_d[k] = db_q[k] + DB_ONE;
                    end
                end
                default: begin
                    state_d[k] = RELEASED;
                end
            endcase
        end
    end

    // State, counter, synchroniser and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q     <= IDLE_PIN;
            sync2_q     <= IDLE_PIN;
            db_q        <= '0;
            hold_q      <= '0;
            rep_q       <= '0;
            key_state_q <= '0;
            press_q     <= '0;
            release_q   <= '0;
            long_q      <= '0;
            repeat_q    <= '0;
            for (int k = 0; k < NUM_KEYS; k++) begin
                state_q[k] <= RELEASED;
            end
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            db_q        <= db_d;
            hold_q      <= hold_d;
            rep_q       <= rep_d;
            key_state_q <= key_state_d;
            press_q     <= press_d;
            release_q   <= release_d;
            long_q      <= long_d;
            repeat_q    <= repeat_d;
            for (int k = 0; k < NUM_KEYS; k++) begin
                state_q[k] <= state_d[k];
            end
        end
    end

    assign key_state     = key_state_q;
    assign press_pulse   = press_q;
    assign release_pulse = release_q;
    assign long_pulse    = long_q;
    assign repeat_pulse  = repeat_q;
    assign any_press     = |press_q;

endmodule

// File: tb/tb_key_debounce_multi.sv
// Directed bench for key_debounce_multi with short debounce/long/repeat times.
module tb_key_debounce_multi;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] key_in;
    logic [3:0] key_state, press_pulse, release_pulse, long_pulse, repeat_pulse;
    logic       any_press;
    int         total = 0;
    int         bad   = 0;

    key_debounce_multi #(
        .NUM_KEYS(4), .ACTIVE_LOW(1), .DEBOUNCE_CYCLES(4),
        .LONG_CYCLES(20), .REPEAT_CYCLES(8), .REPEAT_EN(1)
    ) dut (
        .clk(clk), .rst(rst), .key_in(key_in),
        .key_state(key_state), .press_pulse(press_pulse),
        .release_pulse(release_pulse), .long_pulse(long_pulse),
        .repeat_pulse(repeat_pulse), .any_press(any_press)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_state"},   {28'd0, key_state},     32'd0);
        chk({tag, "_press"},   {28'd0, press_pulse},   32'd0);
        chk({tag, "_release"}, {28'd0, release_pulse}, 32'd0);
        chk({tag, "_long"},    {28'd0, long_pulse},    32'd0);
        chk({tag, "_repeat"},  {28'd0, repeat_pulse},  32'd0);
        chk({tag, "_any"},     {31'd0, any_press},     32'd0);
    endtask

    initial begin
        rst    = 1'b1;
        key_in = 4'hF;
        step();
        step();
        chk_all_zero("reset");
        rst = 1'b0;
        step(); step(); step();
        chk_all_zero("idle");

        // Key 0 press: pulse 7 clocks after the pin edge, then release.
        key_in[0] = 1'b0;
        for (int i = 1; i <= 9; i++) begin
            step();
            chk("t1_press0", {31'd0, press_pulse[0]}, {31'd0, (i == 7)});
            chk("t1_state0", {31'd0, key_state[0]},   {31'd0, (i >= 7)});
            chk("t1_any",    {31'd0, any_press},      {31'd0, (i == 7)});
        end
        key_in[0] = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            step();
            chk("t1_release0", {31'd0, release_pulse[0]}, {31'd0, (i == 7)});
            chk("t1_state0r",  {31'd0, key_state[0]},     {31'd0, (i < 7)});
            chk("t1_long0",    {31'd0, long_pulse[0]},    32'd0);
        end

        // Key 1 bounce of 2 clocks is rejected.
        key_in[1] = 1'b0;
        step(); step();
        key_in[1] = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            step();
            chk_all_zero("t2");
        end

        // Key 2 held 60 clocks: press@7, long@26, repeat every 8 from 34, release 7 after rise.
        key_in[2] = 1'b0;
        for (int i = 1; i <= 60; i++) begin
            step();
            chk("t3_press2",  {31'd0, press_pulse[2]},  {31'd0, (i == 7)});
            chk("t3_long2",   {31'd0, long_pulse[2]},   {31'd0, (i == 26)});
            chk("t3_repeat2", {31'd0, repeat_pulse[2]}, {31'd0, (i >= 34 && ((i - 34) % 8) == 0)});
            chk("t3_state2",  {31'd0, key_state[2]},    {31'd0, (i >= 7)});
        end
        key_in[2] = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            step();
            chk("t3_release2", {31'd0, release_pulse[2]}, {31'd0, (i == 7)});
            chk("t3_rep_off",  {31'd0, repeat_pulse[2]},  32'd0);
            chk("t3_state2r",  {31'd0, key_state[2]},     {31'd0, (i < 7)});
        end

        // Key 2 held with a 2-clock glitch at step 10: long slips from 26 to 29, no release.
        key_in[2] = 1'b0;
        for (int i = 1; i <= 35; i++) begin
            if (i == 11) key_in[2] = 1'b1;
            if (i == 13) key_in[2] = 1'b0;
            step();
            chk("t4_release2", {31'd0, release_pulse[2]}, 32'd0);
            chk("t4_long2",    {31'd0, long_pulse[2]},    {31'd0, (i == 29)});
            chk("t4_state2",   {31'd0, key_state[2]},     {31'd0, (i >= 7)});
        end
        key_in[2] = 1'b1;
        for (int i = 1; i <= 10; i++) step();
        chk("t4_state2_end", {31'd0, key_state[2]}, 32'd0);

        // Keys 0 and 3 together.
        key_in = 4'b0110;
        for (int i = 1; i <= 9; i++) begin
            step();
            chk("t5_press", {28'd0, press_pulse}, (i == 7) ? 32'h9 : 32'h0);
            chk("t5_any",   {31'd0, any_press},   {31'd0, (i == 7)});
        end
        key_in = 4'hF;
        for (int i = 1; i <= 10; i++) step();
        chk_all_zero("t5_end");

        // Reset with key 0 HELD (press pulse high) and key 1 mid-PRESS_WAIT.
        key_in[0] = 1'b0;
        step(); step(); step(); step();
        key_in[1] = 1'b0;
        step(); step(); step();
        chk("t6_pre_press0", {28'd0, press_pulse}, 32'h1);
        chk("t6_pre_state",  {28'd0, key_state},   32'h1);
        rst = 1'b1;
        #1;
        chk_all_zero("t6_async");
        step();
        chk_all_zero("t6_hold");
        rst = 1'b0;
        for (int i = 1; i <= 9; i++) begin
            step();
            chk("t6_press", {28'd0, press_pulse}, (i == 7) ? 32'h3 : 32'h0);
            chk("t6_state", {28'd0, key_state},   (i >= 7) ? 32'h3 : 32'h0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
